// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, field positions,
// opcode and register names, and the fetch state encoding.
package instruction_fetch_unit_pkg;

    localparam int ADDR_WIDTH_DEF   = 16;
    localparam int INSTR_WIDTH_DEF  = 28;
    localparam int OPCODE_WIDTH_DEF = 4;
    localparam int REG_WIDTH_DEF    = 8;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    // Field positions inside the 28-bit instruction word
    localparam int OPCODE_MSB = 27;
    localparam int OPCODE_LSB = 24;
    localparam int DEST_LSB   = 16;
    localparam int SRC0_LSB   = 8;
    localparam int SRC1_LSB   = 0;
    localparam int IMM16_LSB  = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_STO  = 4'h1;
    localparam logic [3:0] OP_IMUL = 4'h2;
    localparam logic [3:0] OP_LED  = 4'h3;

    localparam logic [7:0] R0 = 8'd0;
    localparam logic [7:0] R1 = 8'd1;
    localparam logic [7:0] R2 = 8'd2;
    localparam logic [7:0] R3 = 8'd3;
    localparam logic [7:0] R4 = 8'd4;
    localparam logic [7:0] R5 = 8'd5;
    localparam logic [7:0] R6 = 8'd6;
    localparam logic [7:0] R7 = 8'd7;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter: loadable, holdable, wrapping increment, async active-low reset.
module instruction_fetch_unit_pc_register #(
    parameter int ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] target,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic [ADDR_WIDTH-1:0] pc_r;

    // PC update: redirect beats increment; increment wraps silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else if (load) begin
            pc_r <= target;
        end else if (advance) begin
            pc_r <= pc_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: drives the ROM address, captures the instruction word and
// splits it into decode fields; supports stall and branch redirect with squash.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int INSTR_WIDTH  = INSTR_WIDTH_DEF,
    parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
    parameter int REG_WIDTH    = REG_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                    Clock,
    input  logic                    Reset,
    output logic [ADDR_WIDTH-1:0]   oAddress,
    input  logic [INSTR_WIDTH-1:0]  iInstruction,
    input  logic                    iStall,
    input  logic                    iBranchTaken,
    input  logic [ADDR_WIDTH-1:0]   iBranchTarget,
    output logic                    oValid,
    output logic [ADDR_WIDTH-1:0]   oPC,
    output logic [OPCODE_WIDTH-1:0] oOpcode,
    output logic [REG_WIDTH-1:0]    oDest,
    output logic [REG_WIDTH-1:0]    oSrc0,
    output logic [REG_WIDTH-1:0]    oSrc1,
    output logic [15:0]             oImm16
);

    fetch_state_e           state_r;
    logic [INSTR_WIDTH-1:0] ir_r;
    logic [ADDR_WIDTH-1:0]  pc_out_r;
    logic                   valid_r;
    logic [ADDR_WIDTH-1:0]  pc_s;
    logic                   redirect_s;
    logic                   capture_s;

    // Edge action: BOOT does nothing, otherwise branch > stall > capture
    always_comb begin
        redirect_s = 1'b0;
        capture_s  = 1'b0;
        if (state_r == ST_BOOT) begin
            redirect_s = 1'b0;
            capture_s  = 1'b0;
        end else if (iBranchTaken) begin
            redirect_s = 1'b1;
        end else if (iStall) begin
            capture_s  = 1'b0;
        end else begin
            capture_s  = 1'b1;
        end
    end

    instruction_fetch_unit_pc_register #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_register (
        .clk     (Clock),
        .rst_n   (Reset),
        .load    (redirect_s),
        .target  (iBranchTarget),
        .advance (capture_s),
        .pc      (pc_s)
    );

    // Fetch FSM with the instruction register and its fetch address
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r  <= ST_BOOT;
            ir_r     <= {INSTR_WIDTH{1'b0}};
            pc_out_r <= {ADDR_WIDTH{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_r <= ST_RUN;
                end
                ST_RUN, ST_STALL, ST_FLUSH: begin
                    if (redirect_s) begin
                        valid_r <= 1'b0;
                        state_r <= ST_FLUSH;
                    end else if (capture_s) begin
                        ir_r     <= iInstruction;
                        pc_out_r <= pc_s;
                        valid_r  <= 1'b1;
                        state_r  <= ST_RUN;
                    end else begin
                        // A stalled flush keeps squashing until it can capture
                        state_r <= (state_r == ST_FLUSH) ? ST_FLUSH : ST_STALL;
                    end
                end
                default: begin
                    state_r <= ST_BOOT;
                end
            endcase
        end
    end

    assign oAddress = pc_s;
    assign oValid   = valid_r;
    assign oPC      = pc_out_r;
    assign oOpcode  = ir_r[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign oDest    = ir_r[2*REG_WIDTH +: REG_WIDTH];
    assign oSrc0    = ir_r[REG_WIDTH +: REG_WIDTH];
    assign oSrc1    = ir_r[0 +: REG_WIDTH];
    assign oImm16   = ir_r[15:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized stall/branch phase checked against a behavioural fetch model.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic        iStall;
    logic        iBranchTaken;
    logic [15:0] iBranchTarget;
    logic        oValid;
    logic [15:0] oPC;
    logic [3:0]  oOpcode;
    logic [7:0]  oDest;
    logic [7:0]  oSrc0;
    logic [7:0]  oSrc1;
    logic [15:0] oImm16;

    logic [27:0] rom [0:255];

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: after the boot edge every edge is branch > stall > fetch
    bit          m_boot;
    logic [15:0] m_pc;
    logic        m_valid;
    logic [15:0] m_opc;
    logic [27:0] m_ir;

    always #5 Clock = ~Clock;

    assign iInstruction = rom[oAddress[7:0]];

    instruction_fetch_unit dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .oAddress      (oAddress),
        .iInstruction  (iInstruction),
        .iStall        (iStall),
        .iBranchTaken  (iBranchTaken),
        .iBranchTarget (iBranchTarget),
        .oValid        (oValid),
        .oPC           (oPC),
        .oOpcode       (oOpcode),
        .oDest         (oDest),
        .oSrc0         (oSrc0),
        .oSrc1         (oSrc1),
        .oImm16        (oImm16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot  = 1'b1;
        m_pc    = 16'h0000;
        m_valid = 1'b0;
        m_opc   = 16'h0000;
        m_ir    = 28'h0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  {16'h0, oAddress}, {16'h0, m_pc});
        check({tag, ".valid"}, {31'h0, oValid},   {31'h0, m_valid});
        check({tag, ".pc"},    {16'h0, oPC},      {16'h0, m_opc});
        check({tag, ".op"},    {28'h0, oOpcode},  {28'h0, m_ir[27:24]});
        check({tag, ".dest"},  {24'h0, oDest},    {24'h0, m_ir[23:16]});
        check({tag, ".src0"},  {24'h0, oSrc0},    {24'h0, m_ir[15:8]});
        check({tag, ".src1"},  {24'h0, oSrc1},    {24'h0, m_ir[7:0]});
        check({tag, ".imm"},   {16'h0, oImm16},   {16'h0, m_ir[15:0]});
    endtask

    // Called just after a falling edge; returns just after the next falling edge
    task automatic step(input string tag, input logic s, input logic b, input logic [15:0] t);
        iStall        = s;
        iBranchTaken  = b;
        iBranchTarget = t;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (b) begin
            m_pc    = t;
            m_valid = 1'b0;
        end else if (!s) begin
            m_ir    = rom[m_pc[7:0]];
            m_opc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd1;
        end
        @(posedge Clock);
        #1;
        check_all(tag);
        @(negedge Clock);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 28'($urandom);
        rom[1] = {OP_STO, R1, 16'd60000};
        rom[4] = {OP_IMUL, R3, R1, R2};

        Reset = 1'b0; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = 16'h0000;
        model_reset();
        repeat (2) @(negedge Clock);
        check_all("reset");

        Reset = 1'b1;
        step("boot", 1'b0, 1'b0, 16'h0);
        check("boot.valid", {31'h0, oValid}, 32'd0);
        step("fetch0", 1'b0, 1'b0, 16'h0);
        step("fetch1", 1'b0, 1'b0, 16'h0);
        check("sto.pc",   {16'h0, oPC},     32'd1);
        check("sto.op",   {28'h0, oOpcode}, {28'h0, OP_STO});
        check("sto.dest", {24'h0, oDest},   {24'h0, R1});
        check("sto.imm",  {16'h0, oImm16},  32'h0000EA60);
        step("fetch2", 1'b0, 1'b0, 16'h0);
        step("fetch3", 1'b0, 1'b0, 16'h0);
        step("fetch4", 1'b0, 1'b0, 16'h0);
        check("imul.op",   {28'h0, oOpcode}, {28'h0, OP_IMUL});
        check("imul.dest", {24'h0, oDest},   {24'h0, R3});
        check("imul.src0", {24'h0, oSrc0},   {24'h0, R1});
        check("imul.src1", {24'h0, oSrc1},   {24'h0, R2});

        for (int i = 0; i < 5; i++) begin
            step("stall", 1'b1, 1'b0, 16'h0);
            check("stall.addr", {16'h0, oAddress}, 32'd5);
            check("stall.pc",   {16'h0, oPC},      32'd4);
        end
        step("unstall", 1'b0, 1'b0, 16'h0);
        check("unstall.pc", {16'h0, oPC}, 32'd5);

        step("br10", 1'b0, 1'b1, 16'h0010);
        check("br10.valid", {31'h0, oValid},   32'd0);
        check("br10.addr",  {16'h0, oAddress}, 32'h10);
        step("br10.cap", 1'b0, 1'b0, 16'h0);
        check("br10.pc",    {16'h0, oPC},      32'h10);
        check("br10.v",     {31'h0, oValid},   32'd1);

        step("brstall", 1'b1, 1'b1, 16'h0002);
        for (int i = 0; i < 3; i++) begin
            step("flushhold", 1'b1, 1'b0, 16'h0);
            check("flushhold.valid", {31'h0, oValid}, 32'd0);
        end
        step("flushcap", 1'b0, 1'b0, 16'h0);
        check("flushcap.pc", {16'h0, oPC}, 32'd2);

        step("brwrap", 1'b0, 1'b1, 16'hFFFF);
        step("wrap0", 1'b0, 1'b0, 16'h0);
        check("wrap0.pc", {16'h0, oPC}, 32'hFFFF);
        step("wrap1", 1'b0, 1'b0, 16'h0);
        check("wrap1.pc",   {16'h0, oPC},      32'h0000);
        check("wrap1.addr", {16'h0, oAddress}, 32'h0001);

        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                 16'($urandom_range(0, 65535)));
        end

        step("prestall", 1'b0, 1'b0, 16'h0);
        step("rststall", 1'b1, 1'b0, 16'h0);
        step("rststall", 1'b1, 1'b0, 16'h0);
        #2;
        Reset = 1'b0;
        #1;
        check("midrst.valid", {31'h0, oValid},   32'd0);
        check("midrst.addr",  {16'h0, oAddress}, 32'd0);
        model_reset();
        check_all("midrst");
        @(negedge Clock);
        Reset = 1'b1;
        step("reboot", 1'b0, 1'b0, 16'h0);
        check("reboot.valid", {31'h0, oValid}, 32'd0);
        step("refetch0", 1'b0, 1'b0, 16'h0);
        check("refetch0.valid", {31'h0, oValid}, 32'd1);
        step("refetch1", 1'b0, 1'b0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
